ram_arbiter: RTL and testbench

//  Shares the single-ported RAM between icache (fetch side) and dcache (load/store side).

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/ram_timeout_counter.sv | 37 +++
 rtl/ram_arbiter.sv | 160 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the RAM arbiter and its timeout counter.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

    // Returned to the requester whose transaction was aborted by the timeout.
    localparam word_t ARB_BAD_DATA = 32'hBAD1_BAD1;

endpackage

// File: rtl/ram_timeout_counter.sv
// Counts grant-state cycles without ram_ready; expire flags the final allowed cycle.
module ram_timeout_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic inc,
    output logic expire
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == LAST);

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between icache and dcache: dcache priority with
// starvation relief for fetch, latched address/data, and a transaction timeout.
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  iREN,
    input  word_t iaddr,
    output logic  iwait,
    output word_t iload,
    input  logic  dREN,
    input  logic  dWEN,
    input  word_t daddr,
    input  word_t dstore,
    output logic  dwait,
    output word_t dload,
    output logic  ram_REN,
    output logic  ram_WEN,
    output word_t ram_addr,
    output word_t ram_store,
    input  word_t ram_load,
    input  logic  ram_ready,
    output logic  arb_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    arb_state_t    state_q,   state_d;
    logic [SW-1:0] starve_q,  starve_d;
    word_t         addr_q,    addr_d;
    word_t         store_q,   store_d;
    logic          ren_q,     ren_d;
    logic          wen_q,     wen_d;
    logic          err_q,     err_d;

    logic       tmr_load;
    logic       tmr_inc;
    logic       tmr_expire;
    logic       dreq;
    logic       done;
    logic       decide;
    arb_state_t pick;
    word_t      resp;

    ram_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (CLK),
        .rst_n  (nRST),
        .load   (tmr_load),
        .inc    (tmr_inc),
        .expire (tmr_expire)
    );

    assign dreq = dREN | dWEN;
    // ram_ready on the expiry cycle is still a normal completion.
    assign done = ram_ready | tmr_expire;
    assign resp = ram_ready ? ram_load : ARB_BAD_DATA;

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        addr_d   = addr_q;
        store_d  = store_q;
        ren_d    = ren_q;
        wen_d    = wen_q;
        err_d    = err_q;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        tmr_load = 1'b0;
        tmr_inc  = (state_q != IDLE) && !ram_ready;
        decide   = 1'b0;
        pick     = IDLE;

        case (state_q)
            IDLE: begin
                decide = 1'b1;
                if (dreq && (starve_q < STARVE_LIM)) pick = DGRANT;
                else if (iREN)                      pick = IGRANT;
                else if (dreq)                      pick = DGRANT;
            end
            IGRANT: begin
                if (done) begin
                    iwait  = 1'b0;
                    iload  = resp;
                    err_d  = err_q | ~ram_ready;
                    decide = 1'b1;
                    // Fetch just finished; its request is still high this cycle.
                    if (dreq) pick = DGRANT;
                end
            end
            DGRANT: begin
                if (done) begin
                    dwait  = 1'b0;
                    dload  = resp;
                    err_d  = err_q | ~ram_ready;
                    decide = 1'b1;
                    if (iREN) pick = IGRANT;
                end
            end
            default: begin
                decide = 1'b1;
            end
        endcase

        if (decide) begin
            state_d = pick;
            ren_d   = 1'b0;
            wen_d   = 1'b0;
            if (pick == IGRANT) begin
                addr_d   = iaddr;
                ren_d    = 1'b1;
                starve_d = '0;
                tmr_load = 1'b1;
            end else if (pick == DGRANT) begin
                addr_d   = daddr;
                store_d  = dstore;
                wen_d    = dWEN;
                ren_d    = ~dWEN;
                tmr_load = 1'b1;
                if (!iREN)                       starve_d = '0;
                else if (starve_q != STARVE_LIM) starve_d = starve_q + SW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= '0;
            addr_q   <= '0;
            store_q  <= '0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            err_q    <= err_d;
        end
    end

    assign ram_REN   = ren_q;
    assign ram_WEN   = wen_q;
    assign ram_addr  = addr_q;
    assign ram_store = store_q;
    assign arb_err   = err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed scoreboard bench for ram_arbiter: stimulus queues expected responses,
// a monitor pops them whenever iwait or dwait drops.
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    localparam word_t KEY = 32'h5A5A_0000;
    localparam word_t BAD = 32'hBAD1_BAD1;

    typedef struct packed {
        logic  is_d;
        word_t data;
    } exp_t;

    logic  CLK = 1'b0;
    logic  nRST = 1'b0;
    logic  iREN = 1'b0;
    word_t iaddr = '0;
    logic  iwait;
    word_t iload;
    logic  dREN = 1'b0;
    logic  dWEN = 1'b0;
    word_t daddr = '0;
    word_t dstore = '0;
    logic  dwait;
    word_t dload;
    logic  ram_REN;
    logic  ram_WEN;
    word_t ram_addr;
    word_t ram_store;
    word_t ram_load;
    logic  ram_ready = 1'b0;
    logic  arb_err;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    int lat = 2;
    bit never_ready = 1'b0;
    int rcnt = 0;

    ram_arbiter dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .iwait     (iwait),
        .iload     (iload),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .daddr     (daddr),
        .dstore    (dstore),
        .dwait     (dwait),
        .dload     (dload),
        .ram_REN   (ram_REN),
        .ram_WEN   (ram_WEN),
        .ram_addr  (ram_addr),
        .ram_store (ram_store),
        .ram_load  (ram_load),
        .ram_ready (ram_ready),
        .arb_err   (arb_err)
    );

    always #5 CLK = ~CLK;

    // RAM model: read data is a fixed function of the address; ready after lat strobe cycles.
    assign ram_load = ram_addr ^ KEY;

    always @(posedge CLK) begin
        #1;
        if (!(ram_REN || ram_WEN) || never_ready) begin
            ram_ready = 1'b0;
            rcnt = 0;
        end else if (rcnt >= lat - 1) begin
            ram_ready = 1'b1;
            rcnt = 0;
        end else begin
            ram_ready = 1'b0;
            rcnt++;
        end
    end

    always @(negedge CLK) begin
        if (nRST && (!iwait || !dwait)) begin
            checks++;
            if (!iwait && !dwait) begin
                errors++;
                $display("FAIL both_complete: iwait=%0b dwait=%0b, required only one low", iwait, dwait);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_completion: iwait=%0b dwait=%0b with empty scoreboard", iwait, dwait);
            end else begin
                exp_t  e;
                logic  side;
                word_t data;
                word_t other;
                e     = sb.pop_front();
                side  = !dwait;
                data  = side ? dload : iload;
                other = side ? iload : dload;
                if (side !== e.is_d || data !== e.data || other !== '0) begin
                    errors++;
                    $display("FAIL completion: side=%s load=%h other=%h, required side=%s load=%h other=0",
                             side ? "D" : "I", data, other, e.is_d ? "D" : "I", e.data);
                end else begin
                    $display("txn %s load=%h ok", side ? "D" : "I", data);
                end
            end
        end
    end

    task automatic chk(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge CLK);
        #1;
    endtask

    // Request cycle then first grant cycle, both sampled at the falling edge.
    task automatic to_grant();
        @(negedge CLK);
        @(negedge CLK);
    endtask

    task automatic wait_done(input bit is_d, input int max, output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while ((is_d ? dwait : iwait) && n < max);
        if (is_d ? dwait : iwait) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout: %s wait still high after %0d cycles", is_d ? "D" : "I", n);
        end
    endtask

    initial begin
        int n;

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_iwait", word_t'(iwait), 32'd1);
        chk("rst_dwait", word_t'(dwait), 32'd1);
        chk("rst_iload", iload, 32'd0);
        chk("rst_dload", dload, 32'd0);
        chk("rst_ren", word_t'(ram_REN), 32'd0);
        chk("rst_wen", word_t'(ram_WEN), 32'd0);
        chk("rst_addr", ram_addr, 32'd0);
        chk("rst_store", ram_store, 32'd0);
        chk("rst_err", word_t'(arb_err), 32'd0);
        drive_edge();
        nRST = 1'b1;

        // 1: single fetch, ready on the third grant cycle
        lat = 3;
        drive_edge();
        iREN = 1'b1; iaddr = 32'h40;
        sb.push_back('{is_d: 1'b0, data: 32'h40 ^ KEY});
        to_grant();
        chk("t1_ren", word_t'(ram_REN), 32'd1);
        chk("t1_wen", word_t'(ram_WEN), 32'd0);
        chk("t1_addr", ram_addr, 32'h40);
        chk("t1_iwait_c1", word_t'(iwait), 32'd1);
        wait_done(1'b0, 20, n);
        chk("t1_latency", n, 32'd2);
        drive_edge();
        iREN = 1'b0;
        @(negedge CLK);
        chk("t1_idle_ren", word_t'(ram_REN), 32'd0);
        chk("t1_idle_iwait", word_t'(iwait), 32'd1);

        // 2: simultaneous requests, D first then I back-to-back
        lat = 2;
        drive_edge();
        iREN = 1'b1; iaddr = 32'h44;
        dREN = 1'b1; daddr = 32'h100;
        sb.push_back('{is_d: 1'b1, data: 32'h100 ^ KEY});
        sb.push_back('{is_d: 1'b0, data: 32'h44 ^ KEY});
        to_grant();
        chk("t2_d_addr", ram_addr, 32'h100);
        chk("t2_d_ren", word_t'(ram_REN), 32'd1);
        wait_done(1'b1, 20, n);
        drive_edge();
        dREN = 1'b0;
        @(negedge CLK);
        chk("t2_i_b2b_addr", ram_addr, 32'h44);
        chk("t2_i_b2b_ren", word_t'(ram_REN), 32'd1);
        wait_done(1'b0, 20, n);
        chk("t2_i_latency", n, 32'd1);
        drive_edge();
        iREN = 1'b0;
        @(negedge CLK);

        // 3: four D grants with fetch pending, then fetch is forced, then D again
        iaddr = 32'h300;
        for (int k = 0; k < 4; k++) begin
            drive_edge();
            dREN = 1'b1; iREN = 1'b1; daddr = 32'h200 + 32'(4 * k);
            sb.push_back('{is_d: 1'b1, data: (32'h200 + 32'(4 * k)) ^ KEY});
            to_grant();
            chk("t3_d_grant_addr", ram_addr, 32'h200 + 32'(4 * k));
            drive_edge();
            iREN = 1'b0;
            wait_done(1'b1, 20, n);
        end
        drive_edge();
        iREN = 1'b1; daddr = 32'h400;
        sb.push_back('{is_d: 1'b0, data: 32'h300 ^ KEY});
        sb.push_back('{is_d: 1'b1, data: 32'h400 ^ KEY});
        to_grant();
        chk("t3_forced_i_addr", ram_addr, 32'h300);
        chk("t3_forced_i_ren", word_t'(ram_REN), 32'd1);
        wait_done(1'b0, 20, n);
        drive_edge();
        iREN = 1'b0;
        @(negedge CLK);
        chk("t3_d_after_i_addr", ram_addr, 32'h400);
        wait_done(1'b1, 20, n);
        drive_edge();
        dREN = 1'b0;
        @(negedge CLK);

        // 4: store wins over read
        drive_edge();
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h80; dstore = 32'hCAFE_F00D;
        sb.push_back('{is_d: 1'b1, data: 32'h80 ^ KEY});
        to_grant();
        chk("t4_wen", word_t'(ram_WEN), 32'd1);
        chk("t4_ren", word_t'(ram_REN), 32'd0);
        chk("t4_store", ram_store, 32'hCAFE_F00D);
        chk("t4_addr", ram_addr, 32'h80);
        wait_done(1'b1, 20, n);
        drive_edge();
        dREN = 1'b0; dWEN = 1'b0;
        @(negedge CLK);

        // 5: RAM never ready -> forced completion on grant cycle 64
        never_ready = 1'b1;
        drive_edge();
        dREN = 1'b1; daddr = 32'h500;
        sb.push_back('{is_d: 1'b1, data: BAD});
        to_grant();
        wait_done(1'b1, 100, n);
        chk("t5_timeout_cycle", n + 1, 32'd64);
        chk("t5_err_not_yet", word_t'(arb_err), 32'd0);
        drive_edge();
        dREN = 1'b0; never_ready = 1'b0;
        @(negedge CLK);
        chk("t5_err_set", word_t'(arb_err), 32'd1);
        repeat (5) @(negedge CLK);
        chk("t5_err_sticky", word_t'(arb_err), 32'd1);

        // 6: reset during DGRANT
        never_ready = 1'b1;
        drive_edge();
        dREN = 1'b1; daddr = 32'h600;
        to_grant();
        chk("t6_d_ren", word_t'(ram_REN), 32'd1);
        drive_edge();
        nRST = 1'b0; dREN = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("t6_ren", word_t'(ram_REN), 32'd0);
        chk("t6_wen", word_t'(ram_WEN), 32'd0);
        chk("t6_dwait", word_t'(dwait), 32'd1);
        chk("t6_err", word_t'(arb_err), 32'd0);
        drive_edge();
        nRST = 1'b1; never_ready = 1'b0;

        // Ready arriving on the expiry cycle is a normal completion
        lat = 64;
        drive_edge();
        dREN = 1'b1; daddr = 32'h700;
        sb.push_back('{is_d: 1'b1, data: 32'h700 ^ KEY});
        to_grant();
        wait_done(1'b1, 100, n);
        chk("t7_ready_at_limit", n + 1, 32'd64);
        drive_edge();
        dREN = 1'b0;
        @(negedge CLK);
        chk("t7_no_err", word_t'(arb_err), 32'd0);

        repeat (3) @(negedge CLK);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
